axi_read_responder: RTL and testbench

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

---
 rtl/axi_read_responder_pkg.sv | 26 ++
 rtl/axi_rd_resp_fifo.sv | 52 +++++
 rtl/axi_read_responder.sv | 117 +++++++++++
 tb/tb_axi_read_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_responder_pkg.sv
// Shared AXI read-responder types and response codes.
// Response entry layout is {data, resp} with resp in the low bits.
package axi_read_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_resp_t;

  localparam int RESP_W = $bits(rd_resp_t);

  function automatic rd_resp_t mk_resp(
    input logic        hit,
    input logic [31:0] data
  );
    rd_resp_t r;
    r.data = hit ? data : 32'h0;
    r.resp = hit ? RESP_OKAY : RESP_DECERR;
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_resp_fifo.sv
// Response buffer: synchronous FIFO with first-word fall-through.
// Head entry is visible on rd_data_o whenever empty_o is low.
module axi_rd_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push, pop;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];

  // Pointer and fill-count bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case (1'b1)
        push && !pop: cnt_q <= cnt_q + (AW+1)'(1);
        pop && !push: cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4-Lite read responder: decode, register-file read, ordered replies.
// Define AXI_RD_ERR_CNT_EN to build the saturating DECERR counter.
module axi_read_responder
  import axi_read_responder_pkg::*;
#(
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH   = 10,
  parameter logic [S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [31:0]                 s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        reg_rd_en,
  output logic [REG_ADDR_WIDTH-1:0]   reg_rd_addr,
  input  logic [31:0]                 reg_rd_data,
  output logic [15:0]                 rd_err_count
);

  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int HI = S_AXI_ADDR_WIDTH - 1;
  localparam int LO = REG_ADDR_WIDTH + 2;

  logic [OW-1:0]             occ_q, occ_d;
  logic                      s1_vld_q, s1_hit_q;
  logic [REG_ADDR_WIDTH-1:0] s1_addr_q;
  logic                      s2_vld_q, s2_hit_q;
  logic                      ar_hs, r_hs, hit;
  logic                      f_full, f_empty;
  rd_resp_t                  wr_ent, head;
  logic                      unused_ok;

  assign s_axi_arready = s_axi_aresetn
                      && (occ_q < OW'(FIFO_DEPTH));
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;
  assign hit   = (s_axi_araddr[HI:LO] == BASE_ADDR[HI:LO]);

  assign reg_rd_en   = s1_vld_q && s1_hit_q;
  assign reg_rd_addr = s1_addr_q;

  assign wr_ent = mk_resp(s2_hit_q, reg_rd_data);

  assign s_axi_rvalid = !f_empty;
  assign s_axi_rdata  = s_axi_rvalid ? head.data : 32'h0;
  assign s_axi_rresp  = s_axi_rvalid ? head.resp : 2'b00;

  assign unused_ok = ^{s_axi_arprot, s_axi_araddr[1:0], f_full};

  // Outstanding count covers both pipeline and buffered entries.
  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      ar_hs && !r_hs: occ_d = occ_q + OW'(1);
      r_hs && !ar_hs: occ_d = occ_q - OW'(1);
      default: ;
    endcase
  end

  // Occupancy register and two-stage decode/read pipeline.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      occ_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_hit_q  <= 1'b0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_hit_q  <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      s1_vld_q <= ar_hs;
      s1_hit_q <= ar_hs && hit;
      if (ar_hs) s1_addr_q <= s_axi_araddr[LO-1:2];
      s2_vld_q <= s1_vld_q;
      s2_hit_q <= s1_hit_q;
    end
  end

  axi_rd_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RESP_W)
  ) u_fifo (
    .clk_i     (s_axi_aclk),
    .rst_ni    (s_axi_aresetn),
    .wr_en_i   (s2_vld_q),
    .wr_data_i (wr_ent),
    .rd_en_i   (r_hs),
    .rd_data_o (head),
    .full_o    (f_full),
    .empty_o   (f_empty)
  );

`ifdef AXI_RD_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of DECERR entries entering the buffer.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      err_cnt_q <= '0;
    end else if (s2_vld_q && !s2_hit_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign rd_err_count = err_cnt_q;
`else
  assign rd_err_count = 16'h0;
`endif

endmodule

// File: tb/tb_axi_read_responder.sv
// Randomized bench for axi_read_responder against a queue-based model.
// Model: response visible 3 cycles after accept, in order, depth 4.
module tb_axi_read_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          t;
    logic [31:0] d;
    logic [1:0]  r;
  } ent_t;

  ent_t        q[$];
  int          pm[$];
  int          cyc = 0;
  int          err_exp = 0;
  bit          last_hit = 0;
  logic [9:0]  last_addr = '0;

  always #5 clk = ~clk;

  axi_read_responder dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .reg_rd_en     (rd_en),
    .reg_rd_addr   (rd_addr),
    .reg_rd_data   (rd_data),
    .rd_err_count  (err_cnt)
  );

  function automatic logic [31:0] reg_val(input logic [9:0] a);
    return 32'hCAFE_0000 | {22'h0, a};
  endfunction

  // Register file: data valid the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= reg_val(rd_addr);
    else       rd_data <= $urandom;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] err_model();
`ifdef AXI_RD_ERR_CNT_EN
    return (err_exp > 65535) ? 16'hFFFF : 16'(err_exp);
`else
    return 16'h0;
`endif
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input bit av, input logic [31:0] a, input bit rr);
    bit exp_ar, exp_rv, ar_hs, r_hs, hit;
    ent_t e;
    #1;
    while (pm.size() > 0 && cyc - pm[0] >= 3) begin
      err_exp++;
      void'(pm.pop_front());
    end
    exp_rv = (q.size() > 0) && (cyc - q[0].t >= 3);
    exp_ar = (q.size() < 4);
    check("arready", 64'(arready), 64'(exp_ar));
    check("rvalid", 64'(rvalid), 64'(exp_rv));
    if (exp_rv) begin
      check("rdata", 64'(rdata), 64'(q[0].d));
      check("rresp", 64'(rresp), 64'(q[0].r));
    end
    check("rd_en", 64'(rd_en), 64'(last_hit));
    if (last_hit) check("rd_addr", 64'(rd_addr), 64'(last_addr));
    check("errcnt", 64'(err_cnt), 64'(err_model()));
    arvalid = av;
    araddr  = a;
    rready  = rr;
    hit   = (a[31:12] == 20'h0);
    ar_hs = av && exp_ar;
    r_hs  = exp_rv && rr;
    last_hit  = ar_hs && hit;
    last_addr = a[11:2];
    if (r_hs) void'(q.pop_front());
    if (ar_hs) begin
      e.t = cyc;
      e.d = hit ? reg_val(a[11:2]) : 32'h0;
      e.r = hit ? 2'b00 : 2'b11;
      q.push_back(e);
      if (!hit) pm.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 32'h0, rr);
  endtask

  task automatic chk_reset_outs();
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_errcnt", 64'(err_cnt), 64'd0);
  endtask

  task automatic model_clear();
    q.delete();
    pm.delete();
    last_hit = 0;
    err_exp  = 0;
  endtask

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #1 chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single hit, then single miss.
    step(1, 32'h0000_0010, 1);
    idle(5, 1);
    step(1, 32'h0000_2000, 1);
    idle(5, 1);

    // Backpressure: six offers with rready low, then one drain.
    for (int i = 0; i < 6; i++) step(1, 32'(i * 4), 0);
    idle(2, 0);
    step(0, 32'h0, 1);
    step(1, 32'h0000_0100, 0);
    step(1, 32'h0000_0104, 0);
    idle(8, 1);

    // Streaming, including simultaneous AR/R handshakes.
    for (int i = 0; i < 16; i++) step(1, 32'(i * 4), 1);
    idle(6, 1);

    // Random traffic mixing hits, misses and backpressure.
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:12] = 20'h0;
      else if (a[31:12] == 20'h0) a[20] = 1'b1;
      step(($urandom_range(0, 3) != 0), a,
           ($urandom_range(0, 2) != 0));
    end
    idle(8, 1);

    // Reset with three requests outstanding.
    step(1, 32'h0000_0040, 0);
    step(1, 32'h0000_3000, 0);
    step(1, 32'h0000_0048, 0);
    idle(3, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    arvalid = 1'b0;
    rready  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6, 1);
    step(1, 32'h0000_0020, 1);
    idle(5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
